// File: rtl/cpu_types_pkg.sv
// Purpose: shared CPU types for the fetch stage: word type and fetch FSM state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Purpose: program counter register with next-PC selection and PC+4 adder.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset (PC <= PC_INIT)
//   inc            advance PC by 4 (modulo 2^WORD_W)
//   load           load PC from load_addr, word aligned (wins over inc)
//   load_addr      redirect / pending target
//   pc             current PC
//   pc_4           PC + 4
module pc_unit #(
    parameter int unsigned             WORD_W  = 32,
    parameter logic [WORD_W-1:0]       PC_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic [WORD_W-1:0] load_addr,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_4
);

    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(3);

    // Wraps naturally at the top of the address space.
    assign pc_4 = pc + WORD_W'(4);

    // PC register: load has priority over sequential increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_INIT;
        end else if (load) begin
            pc <= load_addr & ALIGN_MASK;
        end else if (inc) begin
            pc <= pc_4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch stage. Owns the PC, issues word fetches to the icache,
//          drives IF/ID inputs, and handles stalls, redirects, wrong-path discard and halt.
// Ports:
//   CLK, nRST      clock / asynchronous active-low reset
//   ihit, imemload icache response valid / data for imemaddr
//   stall          hold PC and IF outputs
//   redirect,
//   redirect_addr  taken branch / jump resolved this cycle and its target
//   halt           halt committed at WB
//   iREN, imemaddr icache read enable / fetch address (combinational)
//   instr_out,
//   pc_4_out,
//   valid_out      IF/ID payload (bubble = valid 0, instr 0)
//   halted         fetch permanently stopped until reset
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned       WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_addr,
    input  logic              halt,
    output logic              iREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] pc_4_out,
    output logic              valid_out,
    output logic              halted
);

    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(3);

    fetch_state_t      state;
    logic [WORD_W-1:0] pend_addr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_4;
    logic              pc_inc;
    logic              pc_load;
    logic [WORD_W-1:0] pc_load_addr;

    pc_unit #(
        .WORD_W  (WORD_W),
        .PC_INIT (PC_INIT)
    ) u_pc_unit (
        .clk       (CLK),
        .rst_n     (nRST),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (pc_load_addr),
        .pc        (pc),
        .pc_4      (pc_4)
    );

    assign imemaddr = pc;

    // Read enable: an outstanding fetch in DRAIN must complete regardless of stall.
    always_comb begin
        iREN = 1'b0;
        case (state)
            RUN:     iREN = ~stall;
            DRAIN:   iREN = 1'b1;
            default: iREN = 1'b0;
        endcase
    end

    // Next-PC control; mirrors the edge priority halt > redirect > stall > ihit.
    always_comb begin
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = redirect_addr;
        if (!halt) begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        // No fetch in flight (hit this cycle or stalled): load target now.
                        pc_load = ihit || !iREN;
                    end else if (!stall && ihit) begin
                        pc_inc = 1'b1;
                    end
                end
                DRAIN: begin
                    if (ihit) begin
                        pc_load      = 1'b1;
                        pc_load_addr = redirect ? redirect_addr : pend_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM and IF/ID output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            instr_out <= '0;
            pc_4_out  <= '0;
            valid_out <= 1'b0;
            halted    <= 1'b0;
            pend_addr <= '0;
        end else if (halt || state == HALTED) begin
            state     <= HALTED;
            instr_out <= '0;
            valid_out <= 1'b0;
            halted    <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        instr_out <= '0;
                        valid_out <= 1'b0;
                        if (!ihit && iREN) begin
                            // Fetch still outstanding: remember target until it returns.
                            pend_addr <= redirect_addr & ALIGN_MASK;
                            state     <= DRAIN;
                        end
                    end else if (stall) begin
                        // Hold everything; a coincident ihit is ignored and refetched.
                    end else if (ihit) begin
                        instr_out <= imemload;
                        pc_4_out  <= pc_4;
                        valid_out <= 1'b1;
                    end else begin
                        instr_out <= '0;
                        valid_out <= 1'b0;
                    end
                end
                DRAIN: begin
                    instr_out <= '0;
                    valid_out <= 1'b0;
                    if (ihit) begin
                        state <= RUN;
                    end else if (redirect) begin
                        pend_addr <= redirect_addr & ALIGN_MASK;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: scoreboard bench for fetch_stage using directed stimulus.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  nRST;
    logic  ihit;
    word_t imemload;
    logic  stall;
    logic  redirect;
    word_t redirect_addr;
    logic  halt;
    logic  iREN;
    word_t imemaddr;
    word_t instr_out;
    word_t pc_4_out;
    logic  valid_out;
    logic  halted;

    int          checks;
    int          failures;
    logic [63:0] exp_q[$];
    logic [63:0] last_pop;
    bit          last_hold;

    fetch_stage #(
        .WORD_W  (32),
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .imemload      (imemload),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .iREN          (iREN),
        .imemaddr      (imemaddr),
        .instr_out     (instr_out),
        .pc_4_out      (pc_4_out),
        .valid_out     (valid_out),
        .halted        (halted)
    );

    // Icache contents: a fixed pattern of the address.
    function automatic word_t memv(input word_t a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imemload = memv(imemaddr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock of stimulus: check fetch address/enable mid-cycle, optionally push expected IF/ID payload.
    task automatic cyc(input bit h, input bit st, input bit rd, input word_t ra, input bit hl,
                       input word_t ea, input bit er, input bit push, input string nm);
        ihit          = h;
        stall         = st;
        redirect      = rd;
        redirect_addr = ra;
        halt          = hl;
        @(negedge CLK);
        chk({nm, " imemaddr"}, imemaddr, ea);
        chk({nm, " iREN"}, 32'(iREN), 32'(er));
        if (push) exp_q.push_back({memv(ea), ea + 32'd4});
        @(posedge CLK);
        #1;
        last_hold = st && !rd && !hl;
    endtask

    task automatic do_reset(input string nm);
        ihit = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0; halt = 1'b0;
        nRST = 1'b0;
        #2;
        chk({nm, " imemaddr"}, imemaddr, 32'h0000_0000);
        chk({nm, " valid_out"}, 32'(valid_out), 32'd0);
        chk({nm, " instr_out"}, instr_out, 32'd0);
        chk({nm, " halted"}, 32'(halted), 32'd0);
        chk({nm, " iREN"}, 32'(iREN), 32'd1);
        last_hold = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every presented IF/ID payload is compared against the scoreboard.
    always @(negedge CLK) begin
        if (nRST && valid_out) begin
            if (last_hold) begin
                checks++;
                if ({instr_out, pc_4_out} !== last_pop) begin
                    failures++;
                    $display("FAIL held_payload actual=%h required=%h", {instr_out, pc_4_out}, last_pop);
                end
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%h required=none", {instr_out, pc_4_out});
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                checks++;
                if ({instr_out, pc_4_out} !== e) begin
                    failures++;
                    $display("FAIL payload actual=%h required=%h", {instr_out, pc_4_out}, e);
                end
                last_pop = e;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0; last_hold = 1'b0; last_pop = '0;
        ihit = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0; halt = 1'b0;
        nRST = 1'b0;
        #2;
        chk("reset imemaddr", imemaddr, 32'h0);
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset instr_out", instr_out, 32'd0);
        chk("reset pc_4_out", pc_4_out, 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // 1. Straight-line fetch 0x0..0xC.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 32'(i * 4), 1, 1, "t1 seq");

        // 2. Miss for three cycles at 0x10, then continue to 0x20.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 32'h10, 1, 0, "t2 miss");
            chk("t2 bubble valid", 32'(valid_out), 32'd0);
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 32'h10 + 32'(i * 4), 1, 1, "t2 seq");

        // 3. Stall with ihit at 0x20: outputs hold, no fetch; then 0x20 fetched once.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 0, 0, 0, 32'h20, 0, 0, "t3 stall");
            chk("t3 held valid", 32'(valid_out), 32'd1);
        end
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 32'h20 + 32'(i * 4), 1, 1, "t3 seq");

        // 4. Redirect with fetch outstanding at 0x40 -> drain, discard, resume at 0x100.
        cyc(0, 0, 1, 32'h100, 0, 32'h40, 1, 0, "t4 redir");
        cyc(0, 1, 0, 0, 0, 32'h40, 1, 0, "t4 drain stall");
        cyc(1, 0, 0, 0, 0, 32'h40, 1, 0, "t4 drain hit");
        chk("t4 discard valid", 32'(valid_out), 32'd0);
        cyc(1, 0, 0, 0, 0, 32'h100, 1, 1, "t4 target");
        // Multiple redirects while draining: last one wins.
        cyc(0, 0, 1, 32'h300, 0, 32'h104, 1, 0, "t4b redir1");
        cyc(0, 0, 1, 32'h200, 0, 32'h104, 1, 0, "t4b redir2");
        cyc(1, 0, 0, 0, 0, 32'h104, 1, 0, "t4b hit");
        cyc(1, 0, 0, 0, 0, 32'h200, 1, 1, "t4b target");
        // Redirect coincident with the draining hit (target gets aligned).
        cyc(0, 0, 1, 32'h300, 0, 32'h204, 1, 0, "t4c redir1");
        cyc(1, 0, 1, 32'h20B, 0, 32'h204, 1, 0, "t4c redir_hit");
        cyc(1, 0, 0, 0, 0, 32'h208, 1, 1, "t4c target");

        // 5. Redirect coincident with ihit in RUN: wrong-path discarded, 0x103 aligned to 0x100.
        cyc(1, 0, 1, 32'h103, 0, 32'h20C, 1, 0, "t5 redir_hit");
        chk("t5 discard valid", 32'(valid_out), 32'd0);
        cyc(1, 0, 0, 0, 0, 32'h100, 1, 1, "t5 target");
        // Stalled redirect loads directly, then PC wraps past the top.
        cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h104, 0, 0, "t5 stalled redir");
        cyc(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, "t5 top");
        cyc(0, 0, 0, 0, 0, 32'h0, 1, 0, "t5 wrapped");

        // 6. Halt during drain: sticky, fetch off, outputs bubble until reset.
        cyc(1, 0, 1, 32'h50, 0, 32'h0, 1, 0, "t6 redir");
        cyc(0, 0, 1, 32'h60, 0, 32'h50, 1, 0, "t6 to drain");
        cyc(0, 0, 0, 0, 1, 32'h50, 1, 0, "t6 halt");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, (i == 1), 32'h90, 0, 32'h50, 0, 0, "t6 halted");
            chk("t6 halted", 32'(halted), 32'd1);
            chk("t6 valid_out", 32'(valid_out), 32'd0);
            chk("t6 instr_out", instr_out, 32'd0);
        end
        do_reset("t6 reset");
        cyc(1, 0, 0, 0, 0, 32'h0, 1, 1, "t6 restart");

        // Reset in the middle of a drain drops the pending target.
        cyc(0, 0, 1, 32'h80, 0, 32'h4, 1, 0, "t7 redir");
        do_reset("t7 reset");
        cyc(1, 0, 0, 0, 0, 32'h0, 1, 1, "t7 fetch0");
        cyc(1, 0, 0, 0, 0, 32'h4, 1, 1, "t7 fetch4");
        cyc(0, 0, 0, 0, 0, 32'h8, 1, 0, "t7 idle");
        @(negedge CLK);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
